// File: rtl/mem_access_stage.sv
// Memory access stage between EX/MEM and MEM/WB. It issues one data-memory
// access per accepted instruction on a registered req/ack bus, with byte
// strobes and lane replication for stores. Load data is sign- or
// zero-extended. Misaligned, illegal and timed-out accesses are reported
// to writeback as exceptions.
// Latency: 1 cycle for non-memory ops and exceptions; for a load/store,
//   accept N, req N+1, and writeback one cycle after ack is sampled.
// Backpressure: mem_stall is high while an access is being launched or is
//   outstanding; upstream holds EX/MEM. Inputs are ignored in WAIT.
// Ports:
//   clk, reset          clock, async active-high reset
//   mem_*               instruction from EX/MEM (valid strobe, rd, controls,
//                       funct3, address/ALU result, store data)
//   mem_stall           combinational hold request to upstream
//   dmem_*              data-memory request bus (registered outputs)
//   wb_*                registered result toward writeback; wb_valid pulses
module mem_access_stage #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_valid,
  input  logic [4:0]  mem_rd,
  input  logic [1:0]  mem_mem_control,
  input  logic [1:0]  mem_wb_control,
  input  logic [2:0]  mem_funct3,
  input  logic [31:0] mem_result,
  input  logic [31:0] mem_write_data,
  output logic        mem_stall,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_wstrb,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [1:0]  wb_wb_control,
  output logic [31:0] wb_result,
  output logic [31:0] wb_read_data,
  output logic        wb_exc,
  output logic [1:0]  wb_exc_cause
);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  localparam logic [7:0] LP_TIMEOUT = 8'(TIMEOUT_CYCLES);
  localparam logic [1:0] CAUSE_MISALIGN = 2'd0;
  localparam logic [1:0] CAUSE_TIMEOUT  = 2'd1;
  localparam logic [1:0] CAUSE_ILLEGAL  = 2'd2;

  state_t      r_state;
  state_t      w_state_next;

  // Captured access context for the outstanding transaction
  logic [4:0]  r_rd;
  logic [1:0]  r_wbc;
  logic [31:0] r_result;
  logic [2:0]  r_funct3;
  logic        r_is_load;
  logic [7:0]  r_cnt;

  logic        w_rd_en;
  logic        w_wr_en;
  logic        w_any;
  logic        w_both;
  logic        w_ld_illegal;
  logic        w_st_illegal;
  logic        w_illegal;
  logic        w_misalign;
  logic        w_accept;
  logic        w_start;
  logic        w_exc_now;
  logic [1:0]  w_cause_now;
  logic [31:0] w_st_wdata;
  logic [3:0]  w_st_wstrb;
  logic [7:0]  w_ld_byte;
  logic [15:0] w_ld_half;
  logic [31:0] w_ld_data;
  logic [7:0]  w_cnt_inc;
  logic        w_timeout;

  assign w_rd_en = mem_mem_control[1];
  assign w_wr_en = mem_mem_control[0];
  assign w_any   = w_rd_en | w_wr_en;
  assign w_both  = w_rd_en & w_wr_en;

  assign w_ld_illegal = w_rd_en & ~w_wr_en &
                        ((mem_funct3 == 3'b011) | (mem_funct3 == 3'b110) |
                         (mem_funct3 == 3'b111));
  assign w_st_illegal = w_wr_en & ~w_rd_en & (mem_funct3 > 3'b010);
  assign w_illegal    = w_both | w_ld_illegal | w_st_illegal;

  // funct3[1:0] encodes size for both loads and stores (00 B, 01 H, 10 W)
  assign w_misalign = w_any & ~w_illegal &
                      (((mem_funct3[1:0] == 2'b01) & mem_result[0]) |
                       ((mem_funct3[1:0] == 2'b10) & (mem_result[1:0] != 2'b00)));

  assign w_accept    = (r_state == S_IDLE) & mem_valid;
  assign w_start     = w_accept & w_any & ~w_illegal & ~w_misalign;
  assign w_exc_now   = w_illegal | w_misalign;
  assign w_cause_now = w_illegal ? CAUSE_ILLEGAL : CAUSE_MISALIGN;

  assign mem_stall = (r_state == S_WAIT) | w_start;

  // Store lane replication and byte enables
  always_comb begin
    w_st_wdata = mem_write_data;
    w_st_wstrb = 4'b1111;
    case (mem_funct3[1:0])
      2'b00: begin
        w_st_wdata = {4{mem_write_data[7:0]}};
        w_st_wstrb = 4'b0001 << mem_result[1:0];
      end
      2'b01: begin
        w_st_wdata = {2{mem_write_data[15:0]}};
        w_st_wstrb = 4'b0011 << {mem_result[1], 1'b0};
      end
      default: begin
        w_st_wdata = mem_write_data;
        w_st_wstrb = 4'b1111;
      end
    endcase
  end

  // Load lane extraction using the low address bits captured at accept
  always_comb begin
    w_ld_byte = 8'h00;
    case (r_result[1:0])
      2'b00:   w_ld_byte = dmem_rdata[7:0];
      2'b01:   w_ld_byte = dmem_rdata[15:8];
      2'b10:   w_ld_byte = dmem_rdata[23:16];
      default: w_ld_byte = dmem_rdata[31:24];
    endcase
    w_ld_half = r_result[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    w_ld_data = dmem_rdata;
    case (r_funct3)
      3'b000:  w_ld_data = {{24{w_ld_byte[7]}}, w_ld_byte};
      3'b001:  w_ld_data = {{16{w_ld_half[15]}}, w_ld_half};
      3'b100:  w_ld_data = {24'h000000, w_ld_byte};
      3'b101:  w_ld_data = {16'h0000, w_ld_half};
      default: w_ld_data = dmem_rdata;
    endcase
  end

  // Abort on the WAIT cycle whose increment would reach the limit; an ack in
  // that same cycle takes priority and completes normally.
  assign w_cnt_inc = r_cnt + 8'd1;
  assign w_timeout = (r_state == S_WAIT) & ~dmem_ack & (w_cnt_inc == LP_TIMEOUT);

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (w_start) w_state_next = S_WAIT;
      S_WAIT:  if (dmem_ack || w_timeout) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rd          <= 5'd0;
      r_wbc         <= 2'd0;
      r_result      <= 32'd0;
      r_funct3      <= 3'd0;
      r_is_load     <= 1'b0;
      r_cnt         <= 8'd0;
      dmem_req      <= 1'b0;
      dmem_we       <= 1'b0;
      dmem_addr     <= 32'd0;
      dmem_wdata    <= 32'd0;
      dmem_wstrb    <= 4'd0;
      wb_valid      <= 1'b0;
      wb_rd         <= 5'd0;
      wb_wb_control <= 2'd0;
      wb_result     <= 32'd0;
      wb_read_data  <= 32'd0;
      wb_exc        <= 1'b0;
      wb_exc_cause  <= 2'd0;
    end else begin
      wb_valid <= 1'b0;
      wb_exc   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_rd       <= mem_rd;
            r_wbc      <= mem_wb_control;
            r_result   <= mem_result;
            r_funct3   <= mem_funct3;
            r_is_load  <= w_rd_en;
            r_cnt      <= 8'd0;
            dmem_req   <= 1'b1;
            dmem_we    <= w_wr_en;
            dmem_addr  <= {mem_result[31:2], 2'b00};
            dmem_wdata <= w_wr_en ? w_st_wdata : 32'd0;
            dmem_wstrb <= w_wr_en ? w_st_wstrb : 4'b0000;
          end else if (w_accept) begin
            // Non-memory op or rejected access: complete in one cycle
            wb_valid      <= 1'b1;
            wb_rd         <= mem_rd;
            wb_result     <= mem_result;
            wb_read_data  <= 32'd0;
            wb_wb_control <= w_exc_now ? 2'b00 : mem_wb_control;
            wb_exc        <= w_exc_now;
            wb_exc_cause  <= w_exc_now ? w_cause_now : 2'd0;
          end
        end
        S_WAIT: begin
          if (dmem_ack) begin
            dmem_req      <= 1'b0;
            wb_valid      <= 1'b1;
            wb_rd         <= r_rd;
            wb_result     <= r_result;
            wb_wb_control <= r_wbc;
            wb_read_data  <= r_is_load ? w_ld_data : 32'd0;
            wb_exc_cause  <= 2'd0;
          end else if (w_timeout) begin
            dmem_req      <= 1'b0;
            wb_valid      <= 1'b1;
            wb_rd         <= r_rd;
            wb_result     <= r_result;
            wb_wb_control <= 2'b00;
            wb_read_data  <= 32'd0;
            wb_exc        <= 1'b1;
            wb_exc_cause  <= CAUSE_TIMEOUT;
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
